// File: rtl/uart_pkg.sv
// Shared types and constants for the 8-N-1 UART byte receiver.
package uart_pkg;

  localparam int DATA_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 1736;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } rx_state_t;

endpackage

// File: rtl/uart_byte_receiver_if.sv
// Serial line plus received-byte strobes between the RX pin, the receiver and its consumer.
interface uart_byte_receiver_if;
  import uart_pkg::*;

  logic              i_Rx_Serial;
  logic              o_Rx_DV;
  logic [DATA_W-1:0] o_Rx_Byte;
  logic              o_Rx_Frame_Err;

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Frame_Err
  );

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Frame_Err
  );

endinterface

// File: rtl/uart_byte_receiver_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_byte_receiver.sv
// 8-N-1 UART receiver: synchronizes the RX pin, samples each bit at mid-period, strobes bytes or framing errors.
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  uart_byte_receiver_if.slave  rx
);

  localparam int              CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  logic              rx_s;
  rx_state_t         state, state_n;
  logic [CW-1:0]     clk_cnt, clk_cnt_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [DATA_W-1:0] shadow, shadow_n;
  logic [DATA_W-1:0] rx_byte, rx_byte_n;
  logic              dv, dv_n;
  logic              ferr, ferr_n;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (i_Clock),
    .rst (i_Reset),
    .d   (rx.i_Rx_Serial),
    .q   (rx_s)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      rx_byte <= '0;
      dv      <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      rx_byte <= rx_byte_n;
      dv      <= dv_n;
      ferr    <= ferr_n;
    end
  end

  // The shadow register only carries data; it is never observed until a full frame loads it.
  always_ff @(posedge i_Clock) begin
    shadow <= shadow_n;
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    shadow_n  = shadow;
    rx_byte_n = rx_byte;
    dv_n      = 1'b0;
    ferr_n    = 1'b0;

    unique case (state)
      IDLE: begin
        clk_cnt_n = '0;
        bit_idx_n = '0;
        if (!rx_s) state_n = START;
      end

      START: begin
        if (clk_cnt == HALF) begin
          clk_cnt_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end

      DATA: begin
        if (clk_cnt == LAST) begin
          clk_cnt_n         = '0;
          shadow_n[bit_idx] = rx_s;
          bit_idx_n         = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end

      STOP: begin
        if (clk_cnt == LAST) begin
          clk_cnt_n = '0;
          state_n   = CLEANUP;
          if (rx_s) begin
            rx_byte_n = shadow;
            dv_n      = 1'b1;
          end else begin
            ferr_n    = 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end

      // Holding here while the line is low keeps a break from looking like a new start bit.
      CLEANUP: begin
        if (rx_s) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  assign rx.o_Rx_DV        = dv;
  assign rx.o_Rx_Byte      = rx_byte;
  assign rx.o_Rx_Frame_Err = ferr;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Randomized self-checking bench: a frame-level model predicts the byte / framing-error event stream.
module tb_uart_byte_receiver;
  import uart_pkg::*;

  localparam int CPB = 8;
  localparam logic [8:0] EV_ERR = 9'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  uart_byte_receiver_if rx_if ();

  uart_byte_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .rx      (rx_if.slave)
  );

  always #5 clk = ~clk;

  // Model: each transmitted frame yields exactly one event (byte or framing error), in send order.
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  logic [7:0] last_good = 8'h00;
  logic [7:0] prev_byte = 8'h00;
  int         viol_both = 0;
  int         viol_stable = 0;

  always @(negedge clk) begin
    if (rx_if.o_Rx_DV && rx_if.o_Rx_Frame_Err) viol_both <= viol_both + 1;
    if (rx_if.o_Rx_DV) obs_q.push_back({1'b0, rx_if.o_Rx_Byte});
    else if (rx_if.o_Rx_Frame_Err) obs_q.push_back(EV_ERR);
    if (!rx_if.o_Rx_DV && !rst && rx_if.o_Rx_Byte !== prev_byte) viol_stable <= viol_stable + 1;
    prev_byte <= rx_if.o_Rx_Byte;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx_if.i_Rx_Serial = v;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) begin
      exp_q.push_back({1'b0, b});
      last_good = b;
    end else begin
      exp_q.push_back(EV_ERR);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic compare_events(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_event"}, obs_q[i], exp_q[i]);
    chk({tag, "_dv_and_err"}, viol_both, 0);
    chk({tag, "_byte_stable"}, viol_stable, 0);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_if.i_Rx_Serial = 1'b1;
    rst = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    tick();

    chk("rst_dv", rx_if.o_Rx_DV, 1'b0);
    chk("rst_err", rx_if.o_Rx_Frame_Err, 1'b0);
    chk("rst_byte", rx_if.o_Rx_Byte, 8'h00);
    repeat (100) tick();
    chk("idle_byte", rx_if.o_Rx_Byte, 8'h00);
    compare_events("idle");

    send_frame(8'hA5, 1'b1);
    drive_bit(1'b1);
    chk("a5_byte", rx_if.o_Rx_Byte, 8'hA5);
    compare_events("a5");

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (2) drive_bit(1'b1);
    compare_events("b2b");

    for (int g = 1; g <= 3; g++) begin
      rx_if.i_Rx_Serial = 1'b0;
      repeat (g) tick();
      rx_if.i_Rx_Serial = 1'b1;
      repeat (3 * CPB) tick();
    end
    chk("glitch_byte", rx_if.o_Rx_Byte, 8'h3C);
    compare_events("glitch");
    send_frame(8'h96, 1'b1);
    drive_bit(1'b1);
    compare_events("post_glitch");

    send_frame(8'h55, 1'b0);
    repeat (20) drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk("ferr_keep_byte", rx_if.o_Rx_Byte, 8'h96);
    compare_events("ferr");

    // Abort 0x81 during data bit 4; the far end abandons the frame and idles.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h81 >> i));
    rx_if.i_Rx_Serial = 1'b0;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    rx_if.i_Rx_Serial = 1'b1;
    last_good = 8'h00;
    repeat (12) drive_bit(1'b1);
    chk("abort_byte", rx_if.o_Rx_Byte, 8'h00);
    compare_events("abort");
    send_frame(8'h42, 1'b1);
    drive_bit(1'b1);
    chk("after_abort_byte", rx_if.o_Rx_Byte, 8'h42);
    compare_events("after_abort");

    for (int f = 0; f < 40; f++) begin
      logic [7:0] b;
      logic       stop_ok;
      b = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
      send_frame(b, stop_ok);
      if (!stop_ok) begin
        repeat ($urandom_range(0, 20)) drive_bit(1'b0);
        repeat ($urandom_range(1, 3)) drive_bit(1'b1);
      end else begin
        rx_if.i_Rx_Serial = 1'b1;
        repeat ($urandom_range(0, 2 * CPB)) tick();
      end
    end
    repeat (2) drive_bit(1'b1);
    chk("rand_last_byte", rx_if.o_Rx_Byte, last_good);
    compare_events("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_byte_receiver.md
Name: uart_byte_receiver

Overview:
- Asynchronous serial receiver in 8-N-1 format. It converts a raw RX pin into byte-wide words with a one-cycle valid strobe.
- Sits on the engine clock domain (200 MHz) in front of trading_system_top's UART command input (uart_rx_data_out / uart_rx_data_valid).
- Oversamples by counting clock cycles per bit and samples each bit at its midpoint.

Parameters:
- CLKS_PER_BIT, 1736, engine clock cycles per bit period (200 MHz / 115200 baud); minimum legal value 4.

Ports:
- i_Clock  in  1  engine clock; all logic on its rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Rx_Serial  in  1  raw asynchronous RX pin; idle high
- o_Rx_DV  out  1  one-cycle strobe: o_Rx_Byte holds a newly received valid byte
- o_Rx_Byte  out  8  last correctly framed byte, LSB = first data bit
- o_Rx_Frame_Err  out  1  one-cycle strobe: stop bit sampled low; byte discarded

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - state IDLE; counters 0
  - o_Rx_DV=0, o_Rx_Frame_Err=0, o_Rx_Byte=8'h00
  - both synchronizer flops = 1 (idle line)
- Input path: i_Rx_Serial passes through a 2-flop synchronizer; the FSM sees only the synchronized bit rx_s.
- Counter clk_cnt counts 0..CLKS_PER_BIT-1. bit_idx is 3 bits. A shadow shift register accumulates data bits.
- IDLE: clk_cnt=0, bit_idx=0. If rx_s==0, go to START.
- START: increment clk_cnt until it reaches (CLKS_PER_BIT-1)/2 (integer divide), i.e. mid start bit.
  - If rx_s==0 there: clk_cnt←0, go to DATA.
  - Else the edge was a glitch: go to IDLE, no output.
- DATA: increment clk_cnt to CLKS_PER_BIT-1. On that cycle, clk_cnt←0 and shadow[bit_idx]←rx_s.
  - If bit_idx==7: go to STOP.
  - Else bit_idx+1.
- STOP: increment clk_cnt to CLKS_PER_BIT-1, then sample rx_s.
  - If 1: o_Rx_Byte←shadow, o_Rx_DV←1 for exactly one cycle.
  - If 0: o_Rx_Frame_Err←1 for exactly one cycle; o_Rx_Byte unchanged.
  - Either way go to CLEANUP.
- CLEANUP: lasts one cycle; strobes return to 0.
  - Go to IDLE if rx_s==1.
  - Otherwise stay in CLEANUP until rx_s==1. This prevents a break condition or framing error from being decoded as a new start bit.
- Latency: o_Rx_DV rises CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + ~3 cycles after the start-bit falling edge at the pin, i.e. mid stop bit plus synchronizer and register delay.
- o_Rx_Byte is stable between DV pulses. Partial bytes never appear on it.
- Back-to-back frames with a 1-bit stop and zero idle are received without loss: CLEANUP exits while rx_s is still high during the stop bit.
- No handshake or backpressure: the consumer must accept the DV pulse in the same cycle.
- i_Reset mid-frame aborts the frame immediately, with no DV and no error strobe. After release the receiver waits in IDLE for a falling edge. A reset released mid-frame may mis-frame that one partial frame; this is accepted behaviour.
- o_Rx_DV and o_Rx_Frame_Err are never high together.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, CLEANUP)
  - localparams for data width (8) and default CLKS_PER_BIT
- One natural sub-module: sync_2ff (generic 2-flop synchronizer with reset value 1).
- Counter and FSM stay in the top module.

Test Plan:
- Sim with CLKS_PER_BIT=8. Drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1 LSB-first, stop 1) -> single o_Rx_DV pulse, o_Rx_Byte=0xA5, o_Rx_Frame_Err=0.
- Back-to-back 0x00, 0xFF, 0x3C with zero idle gap -> three DV pulses, bytes in order, exactly one DV per frame.
- Low glitch on the idle line shorter than CLKS_PER_BIT/2 cycles -> no DV, state returns to IDLE, o_Rx_Byte unchanged.
- Frame 0x55 with stop bit 0, line then held low for 20 bit times, then released high -> one o_Rx_Frame_Err pulse, no DV, o_Rx_Byte keeps previous value, no spurious frame during the low hold.
- Assert i_Reset for 2 cycles during data bit 4 of frame 0x81, then send a clean 0x42 -> no DV from the aborted frame, next DV carries 0x42.
- Reset check: after reset, o_Rx_DV=0, o_Rx_Frame_Err=0, o_Rx_Byte=0x00 with the line idle for 100 cycles; no strobes.
